// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, byte width and default line timing.
// Used by both the RX and TX paths.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_e;

    localparam int UART_DATA_W = 8;
    localparam int UART_CLK_HZ = 50_000_000;
    localparam int UART_BAUD   = 115200;

    // Sample-tick divider, truncated toward zero.
    function automatic int uart_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side port of the receive FIFO: pop request, FWFT head and occupancy status.
// The consumer (APB register block or bench) uses master; the receiver uses slave.
`timescale 1ns/1ps
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   rd_en_i;
    logic [UART_DATA_W-1:0] rd_data_o;
    logic                   rx_valid_o;
    logic                   full_o;
    logic [CW-1:0]          count_o;

    modport master (output rd_en_i, input rd_data_o, rx_valid_o, full_o, count_o);
    modport slave  (input rd_en_i, output rd_data_o, rx_valid_o, full_o, count_o);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push is accepted while full only when a pop happens in the same cycle.
`timescale 1ns/1ps
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_W,
    parameter int DEPTH = 8
)(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head is masked while empty so the output reads 0 rather than stale storage.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver, 16x oversampled with mid-bit sampling, feeding a byte FIFO
// read through uart_rx_fifo_if; sticky frame-error and overrun flags.
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = UART_CLK_HZ,
    parameter int BAUD       = UART_BAUD,
    parameter int OVERSAMPLE = 16,
    parameter int DEPTH      = 8
)(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          UART_RXD,
    uart_rx_fifo_if.slave rd_if,
    output logic          frame_err_o,
    output logic          overrun_o,
    input  logic          err_clr_i
);
    localparam int DIV   = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);

    logic                   rx_meta_q, rx_s_q, rx_prev_q;
    logic [DIV_W-1:0]       div_q;
    logic                   tick;
    uart_rx_state_e         state_q, state_d;
    logic [SC_W-1:0]        scnt_q, scnt_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic                   frame_err_q, overrun_q;
    logic                   fall, half_smp, bit_smp;
    logic                   push_w, frame_set, shift_en, ovr_set;
    logic                   fifo_empty, fifo_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= UART_RXD;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign tick = (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) div_q <= '0;
        else         div_q <= tick ? '0 : div_q + DIV_W'(1);
    end

    assign fall     = rx_prev_q && !rx_s_q;
    assign half_smp = tick && (scnt_q == SC_W'(OVERSAMPLE/2 - 1));
    assign bit_smp  = tick && (scnt_q == SC_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (fall)     state_d = START;
            START: if (half_smp) state_d = rx_s_q ? IDLE : DATA;
            DATA:  if (bit_smp && bitcnt_q == 3'd7) state_d = STOP;
            STOP:  if (bit_smp)  state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_comb begin
        push_w    = (state_q == STOP) && bit_smp &&  rx_s_q;
        frame_set = (state_q == STOP) && bit_smp && !rx_s_q;
        shift_en  = (state_q == DATA) && bit_smp;
    end

    // Realigning scnt at mid-start makes every later wrap land mid-bit.
    always_comb begin
        scnt_d = scnt_q;
        if (state_q == IDLE)                 scnt_d = '0;
        else if (state_q == START && half_smp) scnt_d = '0;
        else if (bit_smp)                    scnt_d = '0;
        else if (tick)                       scnt_d = scnt_q + SC_W'(1);
    end

    always_comb begin
        bitcnt_d = bitcnt_q;
        if (state_q == START) bitcnt_d = 3'd0;
        else if (shift_en)    bitcnt_d = bitcnt_q + 3'd1;
    end

    assign shreg_d = shift_en ? {rx_s_q, shreg_q[UART_DATA_W-1:1]} : shreg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scnt_q   <= '0;
            bitcnt_q <= '0;
        end else begin
            scnt_q   <= scnt_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shreg_q <= shreg_d;
    end

    // A pop in the same cycle frees the slot, so only an unaccompanied push overruns.
    assign ovr_set = push_w && fifo_full && !rd_if.rd_en_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_set || (frame_err_q && !err_clr_i);
            overrun_q   <= ovr_set   || (overrun_q   && !err_clr_i);
        end
    end

    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_w),
        .wdata_i (shreg_q),
        .pop_i   (rd_if.rd_en_i),
        .rdata_o (rd_if.rd_data_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (rd_if.count_o)
    );

    assign rd_if.rx_valid_o = !fifo_empty;
    assign rd_if.full_o     = fifo_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial line model, scoreboard of expected bytes popped
// by a monitor on every read, plus directed status checks.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH   = 8;
    localparam int BIT_NS  = 1_000_000_000 / UART_BAUD;
    localparam int TICK_NS = 27 * 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic err_clr = 1'b0;
    logic frame_err, overrun;

    int total = 0;
    int bad = 0;
    logic [7:0] sb[$];

    uart_rx_fifo_if #(.DEPTH(DEPTH)) rd_if();

    uart_rx_fifo #(
        .CLK_HZ     (50_000_000),
        .BAUD       (115200),
        .OVERSAMPLE (16),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .UART_RXD    (rxd),
        .rd_if       (rd_if),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .err_clr_i   (err_clr)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic chk_status(input string tag, input int vld, input int cnt,
                              input int full, input int fe, input int ov);
        chk({tag, "_valid"}, 32'(rd_if.rx_valid_o), 32'(vld));
        chk({tag, "_count"}, 32'(rd_if.count_o),    32'(cnt));
        chk({tag, "_full"},  32'(rd_if.full_o),     32'(full));
        chk({tag, "_ferr"},  32'(frame_err),        32'(fe));
        chk({tag, "_ovr"},   32'(overrun),          32'(ov));
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(BIT_NS);
        end
        rxd = stop_bit;
        #(BIT_NS);
        rxd = 1'b1;
    endtask

    task automatic read_one();
        @(posedge clk);
        #1 rd_if.rd_en_i = 1'b1;
        @(posedge clk);
        #1 rd_if.rd_en_i = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    // Raises rd_en for exactly the cycle in which the receiver pushes.
    task automatic coincident_pop();
        logic found;
        found = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(posedge clk);
            #1;
            if (dut.push_w) begin
                rd_if.rd_en_i = 1'b1;
                found = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 rd_if.rd_en_i = 1'b0;
        chk("coincide_found", 32'(found), 32'd1);
    endtask

    // Monitor: every accepted pop must match the oldest expected byte.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (rst_n && rd_if.rd_en_i && rd_if.rx_valid_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %02h required no data", rd_if.rd_data_o);
            end else begin
                e = sb.pop_front();
                chk("pop_data", 32'(rd_if.rd_data_o), 32'(e));
            end
        end
    end

    initial begin : watchdog
        #4_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stim
        rd_if.rd_en_i = 1'b0;
        wait_clks(5);
        chk("rst_data", 32'(rd_if.rd_data_o), 32'h0);
        chk_status("rst", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        wait_clks(50);

        // 1: single byte
        sb.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        wait_clks(4);
        chk("t1_data", 32'(rd_if.rd_data_o), 32'hA5);
        chk_status("t1", 1, 1, 0, 0, 0);
        read_one();
        chk("t1_valid_after", 32'(rd_if.rx_valid_o), 32'd0);
        chk("t1_count_after", 32'(rd_if.count_o), 32'd0);

        // 2: short low glitch
        #(BIT_NS);
        rxd = 1'b0;
        #(3 * TICK_NS);
        rxd = 1'b1;
        #(2 * BIT_NS);
        chk_status("t2", 0, 0, 0, 0, 0);

        // 3: framing error
        send_byte(8'h3C, 1'b0);
        wait_clks(4);
        chk_status("t3", 0, 0, 0, 1, 0);
        #(BIT_NS);
        pulse_clr();
        chk("t3_ferr_clr", 32'(frame_err), 32'd0);

        // 4: nine back-to-back bytes, the ninth overruns
        for (int b = 0; b < 9; b++) begin
            if (b < 8) sb.push_back(8'(b));
            send_byte(8'(b), 1'b1);
        end
        wait_clks(4);
        chk("t4_data", 32'(rd_if.rd_data_o), 32'h00);
        chk_status("t4", 1, 8, 1, 0, 1);
        pulse_clr();
        chk("t4_ovr_clr", 32'(overrun), 32'd0);

        // 5: push and pop in the same cycle while full
        sb.push_back(8'h77);
        fork
            send_byte(8'h77, 1'b1);
            coincident_pop();
        join
        wait_clks(4);
        chk_status("t5", 1, 8, 1, 0, 0);
        chk("t5_head", 32'(rd_if.rd_data_o), 32'h01);
        repeat (5) read_one();
        chk("t5_head_after", 32'(rd_if.rd_data_o), 32'h06);
        chk("t5_count_after", 32'(rd_if.count_o), 32'd3);

        // 6: reset during bit 4 of 0xFF with three bytes queued
        fork
            send_byte(8'hFF, 1'b1);
            begin
                #(BIT_NS * 5 + BIT_NS / 2);
                rst_n = 1'b0;
                #1;
                chk("t6_rst_data", 32'(rd_if.rd_data_o), 32'h0);
                chk_status("t6_rst", 0, 0, 0, 0, 0);
                sb.delete();
                #(BIT_NS);
                rst_n = 1'b1;
            end
        join
        #(BIT_NS);
        sb.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        wait_clks(4);
        chk("t6_data", 32'(rd_if.rd_data_o), 32'h5A);
        chk_status("t6", 1, 1, 0, 0, 0);
        read_one();
        chk("t6_count_after", 32'(rd_if.count_o), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
